// File: rtl/nav_pkg.sv
// Shared navigation codes: run states, maneuver commands, stop drive and error codes.
// Used by the maneuver sequencer and the maneuver executor.
package nav_pkg;

  typedef enum logic [1:0] {
    RUN_INI = 2'b00,
    RUN_EXC = 2'b01,
    RUN_COM = 2'b10,
    RUN_ERR = 2'b11
  } run_t;

  localparam logic [7:0] TURN_LEFT  = 8'h0E;
  localparam logic [7:0] TURN_RIGHT = 8'h0F;
  localparam logic [7:0] STRAIGHT   = 8'h0C;

  localparam logic [4:0] STOP = 5'b00000;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == TURN_LEFT) || (cmd == TURN_RIGHT) || (cmd == STRAIGHT);
  endfunction

endpackage

// File: rtl/sample_confirm.sv
// Counts consecutive qualifying samples, saturating at CONFIRM; done is raised in the cycle
// the count is (or is about to become) full. No backpressure: every valid sample is consumed.
module sample_confirm #(
  parameter int CONFIRM = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic valid,
  input  logic qualify,
  input  logic clear,
  output logic done
);

  localparam int CW = $clog2(CONFIRM + 1);
  localparam logic [CW-1:0] FULL = CW'(CONFIRM);
  localparam logic [CW-1:0] LAST = CW'(CONFIRM - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (valid) begin
      if (!qualify) begin
        cnt <= '0;
      end else if (cnt != FULL) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Looking ahead at the completing sample lets it win against a timeout in the same cycle.
  assign done = !clear && ((cnt == FULL) || (valid && qualify && (cnt == LAST)));

endmodule

// File: rtl/maneuver_executor.sv
// Runs one latched maneuver (turn or straight) to completion, timeout or bad-command error.
// RUN_FLAG/ERR_CODE registered; MOTOR_CMD follows the state; no backpressure on DIST_VALID.
module maneuver_executor
  import nav_pkg::*;
#(
  parameter int INI_HOLD       = 2,
  parameter int TOL            = 2,
  parameter int CONFIRM        = 2,
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] COMMAND,
  input  logic [7:0] PATH,
  input  logic [7:0] COMPARE_DISTANCE,
  input  logic [7:0] DIST_FRONT,
  input  logic [7:0] DIST_SIDE,
  input  logic       DIST_VALID,
  input  logic       CLR,
  output logic [1:0] RUN_FLAG,
  output logic [4:0] MOTOR_CMD,
  output logic [1:0] ERR_CODE
);

  localparam logic [31:0] INI_LAST = 32'(INI_HOLD - 1);
  localparam logic [31:0] EXC_LAST = 32'(TIMEOUT_CYCLES - 1);

  run_t        state;
  run_t        state_nxt;
  logic [1:0]  err_q;
  logic [1:0]  err_nxt;
  logic        latch;
  logic [31:0] ini_cnt;
  logic [31:0] exc_cnt;
  logic [4:0]  cmd_q;
  logic [7:0]  path_q;
  logic [7:0]  cmp_q;
  logic [8:0]  side_diff;
  logic [8:0]  side_abs;
  logic        qualify;
  logic        in_exc;
  logic        sample_vld;
  logic        done;

  assign in_exc     = (state == RUN_EXC);
  assign sample_vld = DIST_VALID && in_exc;

  // Side error is taken in 9 bits so the subtraction never wraps.
  always_comb begin
    side_diff = {1'b0, DIST_SIDE} - {1'b0, cmp_q};
    side_abs  = side_diff[8] ? (~side_diff + 9'd1) : side_diff;
    if (cmd_q == STRAIGHT[4:0]) begin
      qualify = (DIST_FRONT <= path_q);
    end else begin
      qualify = (side_abs <= 9'(TOL));
    end
  end

  sample_confirm #(
    .CONFIRM(CONFIRM)
  ) u_confirm (
    .CLK     (CLK),
    .RST     (RST),
    .valid   (sample_vld),
    .qualify (qualify),
    .clear   (!in_exc),
    .done    (done)
  );

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    latch     = 1'b0;
    case (state)
      RUN_INI: begin
        if (ini_cnt == INI_LAST) begin
          latch = 1'b1;
          if (is_known_cmd(COMMAND)) begin
            state_nxt = RUN_EXC;
          end else begin
            state_nxt = RUN_ERR;
            err_nxt   = ERR_BAD_CMD;
          end
        end
      end
      RUN_EXC: begin
        if (done) begin
          state_nxt = RUN_COM;
        end else if (exc_cnt == EXC_LAST) begin
          state_nxt = RUN_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      RUN_COM: state_nxt = RUN_INI;
      RUN_ERR: begin
        if (CLR) begin
          state_nxt = RUN_INI;
          err_nxt   = ERR_NONE;
        end
      end
      default: state_nxt = RUN_INI;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= RUN_INI;
      err_q   <= ERR_NONE;
      ini_cnt <= '0;
      exc_cnt <= '0;
      cmd_q   <= '0;
      path_q  <= '0;
      cmp_q   <= '0;
    end else begin
      state   <= state_nxt;
      err_q   <= err_nxt;
      ini_cnt <= ((state == RUN_INI) && !latch) ? ini_cnt + 32'd1 : '0;
      exc_cnt <= in_exc ? exc_cnt + 32'd1 : '0;
      if (latch) begin
        cmd_q  <= COMMAND[4:0];
        path_q <= PATH;
        cmp_q  <= COMPARE_DISTANCE;
      end
    end
  end

  assign RUN_FLAG  = state;
  assign MOTOR_CMD = in_exc ? cmd_q : STOP;
  assign ERR_CODE  = err_q;

endmodule

// File: tb/tb_maneuver_executor.sv
// Directed scenarios plus randomized traffic, all checked every cycle against a behavioural model.
module tb_maneuver_executor;

  localparam int INI_HOLD = 2;
  localparam int TOL      = 2;
  localparam int CONFIRM  = 2;
  localparam int TMO      = 100;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] COMMAND;
  logic [7:0] PATH;
  logic [7:0] COMPARE_DISTANCE;
  logic [7:0] DIST_FRONT;
  logic [7:0] DIST_SIDE;
  logic       DIST_VALID;
  logic       CLR;
  logic [1:0] RUN_FLAG;
  logic [4:0] MOTOR_CMD;
  logic [1:0] ERR_CODE;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  maneuver_executor #(
    .INI_HOLD       (INI_HOLD),
    .TOL            (TOL),
    .CONFIRM        (CONFIRM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .COMMAND          (COMMAND),
    .PATH             (PATH),
    .COMPARE_DISTANCE (COMPARE_DISTANCE),
    .DIST_FRONT       (DIST_FRONT),
    .DIST_SIDE        (DIST_SIDE),
    .DIST_VALID       (DIST_VALID),
    .CLR              (CLR),
    .RUN_FLAG         (RUN_FLAG),
    .MOTOR_CMD        (MOTOR_CMD),
    .ERR_CODE         (ERR_CODE)
  );

  // Model: phase 0 idle-hold, 1 running, 2 complete, 3 error.
  typedef struct {
    int phase;
    int hold;
    int cmd;
    int path;
    int tgt;
    int streak;
    int run_cycles;
    int err;
  } model_t;

  model_t m;

  function automatic bit sample_ok(model_t s, int front, int side);
    int d;
    if (s.cmd == 12) return front <= s.path;
    d = side - s.tgt;
    if (d < 0) d = -d;
    return d <= TOL;
  endfunction

  function automatic model_t step(model_t s, int cmd, int path, int tgt, int front, int side,
                                  bit vld, bit clr);
    model_t n = s;
    int k;
    case (s.phase)
      0: begin
        if (s.hold + 1 >= INI_HOLD) begin
          n.cmd = cmd; n.path = path; n.tgt = tgt;
          n.hold = 0; n.streak = 0; n.run_cycles = 0;
          if (cmd == 14 || cmd == 15 || cmd == 12) n.phase = 1;
          else begin n.phase = 3; n.err = 1; end
        end else begin
          n.hold = s.hold + 1;
        end
      end
      1: begin
        k = s.streak;
        if (vld) k = sample_ok(s, front, side) ? ((k + 1 > CONFIRM) ? CONFIRM : k + 1) : 0;
        if (k >= CONFIRM) n.phase = 2;
        else if (s.run_cycles + 1 >= TMO) begin n.phase = 3; n.err = 2; end
        n.streak = k;
        n.run_cycles = s.run_cycles + 1;
      end
      2: begin n.phase = 0; n.hold = 0; end
      default: if (clr) begin n.phase = 0; n.hold = 0; n.err = 0; end
    endcase
    return n;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) m <= '{default: 0};
    else m <= step(m, int'(COMMAND), int'(PATH), int'(COMPARE_DISTANCE), int'(DIST_FRONT),
                   int'(DIST_SIDE), DIST_VALID, CLR);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_run_flag", int'(RUN_FLAG), m.phase);
      chk("model_motor_cmd", int'(MOTOR_CMD), (m.phase == 1) ? (m.cmd % 32) : 0);
      chk("model_err_code", int'(ERR_CODE), m.err);
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic sample(input int front, input int side);
    DIST_FRONT = 8'(front);
    DIST_SIDE  = 8'(side);
    DIST_VALID = 1'b1;
    @(negedge CLK);
    DIST_VALID = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int r;
    int sd;
    RST = 1'b1; COMMAND = '0; PATH = '0; COMPARE_DISTANCE = '0;
    DIST_FRONT = '0; DIST_SIDE = '0; DIST_VALID = 1'b0; CLR = 1'b0;
    repeat (2) tick();
    chk("reset_run_flag", int'(RUN_FLAG), 0);
    chk("reset_motor", int'(MOTOR_CMD), 0);
    chk("reset_err", int'(ERR_CODE), 0);
    RST = 1'b0;
    chk_en = 1'b1;

    // Left turn, target 40: 50 misses, 41 and 39 confirm.
    COMMAND = 8'h0E; COMPARE_DISTANCE = 8'd40;
    tick(); chk("t1_still_ini", int'(RUN_FLAG), 0);
    tick(); chk("t1_exc_entry", int'(RUN_FLAG), 1);
    chk("t1_motor_exc", int'(MOTOR_CMD), 14);
    sample(0, 50); chk("t1_after_50", int'(RUN_FLAG), 1);
    sample(0, 41); chk("t1_after_41", int'(RUN_FLAG), 1);
    sample(0, 39); chk("t1_com", int'(RUN_FLAG), 2);
    chk("t1_motor_com", int'(MOTOR_CMD), 0);
    tick(); chk("t1_back_ini", int'(RUN_FLAG), 0);

    // Straight, PATH 16: the 20 sample breaks the streak.
    COMMAND = 8'h0C; PATH = 8'd16;
    tick(); tick(); chk("t2_exc_entry", int'(RUN_FLAG), 1);
    chk("t2_motor_exc", int'(MOTOR_CMD), 12);
    sample(30, 0); chk("t2_after_30", int'(RUN_FLAG), 1);
    sample(15, 0); chk("t2_after_15", int'(RUN_FLAG), 1);
    sample(20, 0); chk("t2_after_20", int'(RUN_FLAG), 1);
    sample(16, 0); chk("t2_after_16", int'(RUN_FLAG), 1);
    sample(10, 0); chk("t2_com", int'(RUN_FLAG), 2);
    tick(); chk("t2_back_ini", int'(RUN_FLAG), 0);

    // Operand changes during EXC must not disturb the latched turn.
    COMMAND = 8'h0E; COMPARE_DISTANCE = 8'd100;
    tick(); tick(); chk("t6_exc_entry", int'(RUN_FLAG), 1);
    COMMAND = 8'h0C; PATH = 8'd255; COMPARE_DISTANCE = 8'd0;
    sample(0, 0); chk("t6_motor_hold", int'(MOTOR_CMD), 14);
    sample(0, 0); chk("t6_no_complete", int'(RUN_FLAG), 1);
    sample(0, 101); chk("t6_motor_hold2", int'(MOTOR_CMD), 14);
    sample(0, 99); chk("t6_com", int'(RUN_FLAG), 2);
    tick();

    // Unknown command goes to a sticky error until CLR.
    COMMAND = 8'h05;
    tick(); tick(); chk("t3_err_flag", int'(RUN_FLAG), 3);
    chk("t3_err_code", int'(ERR_CODE), 1);
    chk("t3_motor_stop", int'(MOTOR_CMD), 0);
    repeat (3) sample(0, 0);
    chk("t3_sticky", int'(RUN_FLAG), 3);
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("t3_clr_ini", int'(RUN_FLAG), 0);
    chk("t3_clr_code", int'(ERR_CODE), 0);

    // Straight with nothing qualifying must time out after exactly TMO cycles.
    COMMAND = 8'h0C; PATH = 8'd5;
    tick(); tick(); chk("t4_exc_entry", int'(RUN_FLAG), 1);
    cnt = 0;
    while (RUN_FLAG == 2'b01 && cnt < 150) begin
      DIST_FRONT = 8'd200;
      DIST_VALID = 1'($urandom_range(0, 1));
      CLR = (cnt == 10);
      tick();
      cnt++;
    end
    DIST_VALID = 1'b0; CLR = 1'b0;
    chk("t4_timeout_cycles", cnt, 100);
    chk("t4_err_flag", int'(RUN_FLAG), 3);
    chk("t4_err_code", int'(ERR_CODE), 2);
    CLR = 1'b1; tick(); CLR = 1'b0;

    // Asynchronous reset mid-turn, then a fresh hold and a cleared streak.
    COMMAND = 8'h0F; COMPARE_DISTANCE = 8'd60;
    tick(); tick(); chk("t5_exc_entry", int'(RUN_FLAG), 1);
    sample(0, 60);
    #1 RST = 1'b1;
    #1;
    chk("t5_async_flag", int'(RUN_FLAG), 0);
    chk("t5_async_motor", int'(MOTOR_CMD), 0);
    chk("t5_async_err", int'(ERR_CODE), 0);
    tick();
    RST = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (RUN_FLAG == 2'b00 && cnt < 10);
    chk("t5_fresh_hold", cnt, 2);
    sample(0, 60); chk("t5_streak_cleared", int'(RUN_FLAG), 1);
    sample(0, 61); chk("t5_com", int'(RUN_FLAG), 2);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      COMMAND = (r < 3) ? 8'h0E : (r < 6) ? 8'h0F : (r < 8) ? 8'h0C : 8'($urandom);
      PATH = 8'($urandom_range(0, 40));
      COMPARE_DISTANCE = 8'($urandom);
      sd = m.tgt + $urandom_range(0, 8) - 4;
      if (sd < 0) sd = 0;
      if (sd > 255) sd = 255;
      DIST_SIDE  = 8'(sd);
      DIST_FRONT = 8'($urandom_range(0, 50));
      DIST_VALID = 1'($urandom_range(0, 1));
      CLR = ($urandom_range(0, 15) == 0);
      tick();
    end
    DIST_VALID = 1'b0; CLR = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
